iir_biquad_mc: RTL



---
 rtl/iir_pkg.sv | 26 ++
 rtl/iir_round_sat.sv | 38 +++
 rtl/iir_biquad_mc.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/iir_pkg.sv
// Shared definitions for the multi-channel biquad: FSM states, coefficient
// addresses and the accumulator width rule.
package iir_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MAC0,
        MAC1,
        MAC2,
        MAC3,
        MAC4,
        OUT
    } state_t;

    localparam logic [2:0] COEF_A0 = 3'd0;
    localparam logic [2:0] COEF_A1 = 3'd1;
    localparam logic [2:0] COEF_A2 = 3'd2;
    localparam logic [2:0] COEF_B1 = 3'd3;
    localparam logic [2:0] COEF_B2 = 3'd4;

    // Five products of DW x CW bits need three guard bits to never overflow.
    function automatic int acc_width(input int dw, input int cw);
        return dw + cw + 3;
    endfunction

endpackage

// File: rtl/iir_round_sat.sv
// Rounds the wide accumulator to DW bits (nearest, ties toward +inf).
// Build option IIR_SAT_EN: saturate instead of wrapping on overflow.
module iir_round_sat
    import iir_pkg::*;
#(
    parameter int AW   = 19,
    parameter int DW   = 8,
    parameter int FRAC = 6
) (
    input  logic signed [AW-1:0] acc,
    output logic signed [DW-1:0] y
);

    localparam logic signed [AW-1:0] HALF = AW'(1 << (FRAC - 1));

`ifdef IIR_SAT_EN
    localparam logic signed [AW-1:0] YMAX = AW'((1 << (DW - 1)) - 1);
    localparam logic signed [AW-1:0] YMIN = AW'(-(1 << (DW - 1)));

    logic signed [AW-1:0] rounded;

    always_comb begin
        rounded = (acc + HALF) >>> FRAC;
        if (rounded > YMAX) begin
            y = YMAX[DW-1:0];
        end else if (rounded < YMIN) begin
            y = YMIN[DW-1:0];
        end else begin
            y = rounded[DW-1:0];
        end
    end
`else
    always_comb begin
        y = DW'((acc + HALF) >>> FRAC);
    end
`endif

endmodule

// File: rtl/iir_biquad_mc.sv
// Multi-channel programmable biquad sharing one multiplier over five taps.
// Build option IIR_SAT_EN selects saturating output (see iir_round_sat).
module iir_biquad_mc
    import iir_pkg::*;
#(
    parameter int DW   = 8,
    parameter int CW   = 8,
    parameter int FRAC = 6,
    parameter int NCH  = 2,
    parameter int CHW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_data,
    input  logic [CHW-1:0]       in_ch,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] out_data,
    output logic [CHW-1:0]       out_ch,
    input  logic                 coef_we,
    input  logic [2:0]           coef_addr,
    input  logic signed [CW-1:0] coef_wdata,
    output logic                 err_ch
);

    localparam int AW = acc_width(DW, CW);

    state_t state, state_next;

    logic signed [AW-1:0] acc, acc_sum, prod;
    logic signed [DW-1:0] x_lat, mul_op, y_new;
    logic signed [CW-1:0] mul_coef;
    logic signed [CW-1:0] coef [5];
    logic [CHW-1:0]       ch_lat;
    logic signed [DW-1:0] xh1 [NCH];
    logic signed [DW-1:0] xh2 [NCH];
    logic signed [DW-1:0] yh1 [NCH];
    logic signed [DW-1:0] yh2 [NCH];
    logic                 ch_ok, accept;

    assign ch_ok  = int'(in_ch) < NCH;
    assign accept = (state == IDLE) && in_valid && ch_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (accept) state_next = MAC0;
            end
            MAC0: state_next = MAC1;
            MAC1: state_next = MAC2;
            MAC2: state_next = MAC3;
            MAC3: state_next = MAC4;
            MAC4: state_next = OUT;
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand selection for the single shared multiplier, one tap per MAC state.
    always_comb begin
        mul_coef = coef[COEF_A0];
        mul_op   = x_lat;
        case (state)
            MAC1: begin
                mul_coef = coef[COEF_A1];
                mul_op   = xh1[ch_lat];
            end
            MAC2: begin
                mul_coef = coef[COEF_A2];
                mul_op   = xh2[ch_lat];
            end
            MAC3: begin
                mul_coef = coef[COEF_B1];
                mul_op   = yh1[ch_lat];
            end
            MAC4: begin
                mul_coef = coef[COEF_B2];
                mul_op   = yh2[ch_lat];
            end
            default: ;
        endcase
        prod    = AW'(mul_coef) * AW'(mul_op);
        acc_sum = acc + prod;
    end

    // The MAC4 result is rounded straight from acc_sum so the last tap is included.
    iir_round_sat #(
        .AW  (AW),
        .DW  (DW),
        .FRAC(FRAC)
    ) u_round (
        .acc(acc_sum),
        .y  (y_new)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            acc      <= '0;
            x_lat    <= '0;
            ch_lat   <= '0;
            out_data <= '0;
            out_ch   <= '0;
            err_ch   <= 1'b0;
            coef[COEF_A0] <= CW'(1 << FRAC);
            coef[COEF_A1] <= '0;
            coef[COEF_A2] <= '0;
            coef[COEF_B1] <= '0;
            coef[COEF_B2] <= '0;
            for (int i = 0; i < NCH; i++) begin
                xh1[i] <= '0;
                xh2[i] <= '0;
                yh1[i] <= '0;
                yh2[i] <= '0;
            end
        end else begin
            err_ch <= (state == IDLE) && in_valid && !ch_ok;
            if ((state == IDLE) && coef_we && (coef_addr <= COEF_B2)) begin
                coef[coef_addr] <= coef_wdata;
            end
            if (accept) begin
                x_lat  <= in_data;
                ch_lat <= in_ch;
                acc    <= '0;
            end else if ((state != IDLE) && (state != OUT)) begin
                acc <= acc_sum;
            end
            if (state == MAC4) begin
                out_data     <= y_new;
                out_ch       <= ch_lat;
                xh2[ch_lat]  <= xh1[ch_lat];
                xh1[ch_lat]  <= x_lat;
                yh2[ch_lat]  <= yh1[ch_lat];
                yh1[ch_lat]  <= y_new;
            end
        end
    end

endmodule
